vram_arb: RTL and testbench
===========================

VRAM_ARB -- requirements
Module: vram_arb

Interface
REQ-001 SHALL have parameter REGS_PRIO, default 0, meaning 0 = regs/blit round-robin and 1 = regs strictly above blit.
REQ-002 SHALL have port clk, input, 1, system clock (video pixel clock); all logic is on posedge.
REQ-003 SHALL have port reset_i, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port vgen_sel_i, input, 1, video fetch read request.
REQ-005 SHALL have port vgen_addr_i, input, 16, video fetch address.
REQ-006 SHALL have port vgen_ack_o, output, 1, video read data valid on data_o.
REQ-007 SHALL have ports regs_sel_i (in, 1), regs_wr_i (in, 1), regs_wr_mask_i (in, 4), regs_addr_i (in, 16), regs_data_i (in, 16) and regs_ack_o (out, 1), forming the host register requester.
REQ-008 SHALL have ports blit_sel_i (in, 1), blit_wr_i (in, 1), blit_wr_mask_i (in, 4), blit_addr_i (in, 16), blit_data_i (in, 16) and blit_ack_o (out, 1), forming the blitter requester.
REQ-009 SHALL have ports vram_sel_o (out, 1), vram_wr_o (out, 1), vram_wr_mask_o (out, 4), vram_addr_o (out, 16), vram_data_o (out, 16) and vram_data_i (in, 16), forming the VRAM port (1-cycle synchronous read).
REQ-010 SHALL have port data_o, output, 16, read data broadcast to all requesters, qualified by each requester's ack.

Function
REQ-011 SHALL sample requests in cycle N, drive the registered vram_* outputs for exactly one cycle in N+1, and assert the winner's ack for one cycle in N+2.
REQ-012 SHALL drive data_o = vram_data_i combinationally in every cycle.
REQ-013 SHALL give ack for writes with the same N+2 timing as reads.
REQ-014 SHALL make at most one grant per cycle, giving an aggregate throughput of one access per cycle.
REQ-015 SHALL give vgen absolute priority; vgen is never stalled, may request every cycle, and each request at N is acked at N+2 (pipelined).
REQ-016 SHALL treat vgen accesses as reads: vram_wr_o=0 and vram_wr_mask_o=4'b1111.
REQ-017 SHALL keep a pending flag per regs/blit: set on grant, cleared in the ack cycle; a requester with pending=1 is ineligible even if its sel is high.
REQ-018 SHALL cause the requester to drop sel or present a new access in the cycle after ack; sel held high at N+3 is a new request.
REQ-019 SHALL, with REGS_PRIO=0 and both regs and blit eligible without vgen, grant the requester not favoured last; a 1-bit rr_ptr toggles only on a regs or blit grant.
REQ-020 SHALL, on a vgen win, leave rr_ptr unchanged.
REQ-021 SHALL, with REGS_PRIO=1, grant regs whenever eligible and leave rr_ptr unused.
REQ-022 SHALL, on a grant, drive vram_sel_o=1 and take vram_wr_o/vram_wr_mask_o/vram_addr_o/vram_data_o from the winner.
REQ-023 SHALL, with no grant, drive vram_sel_o=0 and vram_wr_o=0, with address, data and mask holding their previous values.
REQ-024 SHALL pipeline a 2-stage grant-id (none/vgen/regs/blit) to route acks; acks are mutually exclusive.
REQ-025 SHALL pass the address through unmodified with no wrap logic; 16'hFFFF is a legal address.
REQ-026 SHALL ignore a requester's sel deasserted before ack; the access still completes and is acked.
REQ-027 SHALL NOT allow a regs or blit request to be starved by the other requester under REGS_PRIO=0: it is granted within 3 non-vgen cycles of becoming eligible.

Reset
REQ-028 SHALL, on reset_i=1, drive vram_sel_o=0, vram_wr_o=0, vram_wr_mask_o=4'b1111, vram_addr_o=0 and vram_data_o=0.
REQ-029 SHALL, on reset_i=1, clear all acks, clear the pending flags, clear the grant pipeline and set rr_ptr to favour regs.
REQ-030 SHALL, on reset mid-access, cancel in-flight accesses: no ack is issued after reset for grants made before it.

Verification
REQ-031 SHALL cover blit read: blit_sel_i=1, blit_addr_i=16'h1234, vram_data_i=16'hBEEF at N+2 -> vram_sel_o=1 and vram_addr_o=16'h1234 at N+1; blit_ack_o=1 and data_o=16'hBEEF at N+2.
REQ-032 SHALL cover the 3-way collision: vgen, regs and blit all request at N -> vgen is granted at N, regs at N+1, blit at N+2 (vgen idle after N); acks arrive at N+2, N+3 and N+4.
REQ-033 SHALL cover round-robin: regs and blit requesting continuously with REGS_PRIO=0 and no vgen -> grants alternate regs, blit, regs, blit; neither is granted twice within 3 cycles.
REQ-034 SHALL cover the blit write mask: blit_wr_i=1, blit_wr_mask_i=4'b0101, blit_data_i=16'hA5A5, addr 16'hFFFF -> vram_wr_o=1, mask 4'b0101, data 16'hA5A5, addr 16'hFFFF at N+1; ack at N+2.
REQ-035 SHALL cover vgen streaming: vgen requests on 8 consecutive cycles with blit requesting -> 8 vgen acks on consecutive cycles, then the blit grant on the cycle after the last vgen request.
REQ-036 SHALL cover reset in flight: reset_i=1 at N+1 after a regs grant at N -> regs_ack_o stays 0, and all outputs hold their reset values.

Source files
------------

// File: rtl/vram_arb.sv
// rtl/vram_arb.sv - VRAM arbiter: vgen absolute priority, regs/blit round-robin or fixed, 2-stage ack pipeline
module vram_arb #(
  parameter int unsigned REGS_PRIO = 0
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        vgen_sel_i,
  input  logic [15:0] vgen_addr_i,
  output logic        vgen_ack_o,
  input  logic        regs_sel_i,
  input  logic        regs_wr_i,
  input  logic [3:0]  regs_wr_mask_i,
  input  logic [15:0] regs_addr_i,
  input  logic [15:0] regs_data_i,
  output logic        regs_ack_o,
  input  logic        blit_sel_i,
  input  logic        blit_wr_i,
  input  logic [3:0]  blit_wr_mask_i,
  input  logic [15:0] blit_addr_i,
  input  logic [15:0] blit_data_i,
  output logic        blit_ack_o,
  output logic        vram_sel_o,
  output logic        vram_wr_o,
  output logic [3:0]  vram_wr_mask_o,
  output logic [15:0] vram_addr_o,
  output logic [15:0] vram_data_o,
  input  logic [15:0] vram_data_i,
  output logic [15:0] data_o
);

  typedef enum logic [1:0] {
    GID_NONE = 2'd0,
    GID_VGEN = 2'd1,
    GID_REGS = 2'd2,
    GID_BLIT = 2'd3
  } gid_e;

  gid_e        w_gid;
  gid_e        r_gid1;
  gid_e        r_gid2;
  logic        w_regs_elig;
  logic        w_blit_elig;
  logic        r_regs_pend;
  logic        r_blit_pend;
  logic        r_rr_ptr;
  logic        r_sel;
  logic        r_wr;
  logic [3:0]  r_mask;
  logic [15:0] r_addr;
  logic [15:0] r_data;

  // r_rr_ptr = 0 favours regs, 1 favours blit
  always_comb begin
    w_regs_elig = regs_sel_i & ~r_regs_pend;
    w_blit_elig = blit_sel_i & ~r_blit_pend;
    w_gid       = GID_NONE;
    if (vgen_sel_i) begin
      w_gid = GID_VGEN;
    end else if (w_regs_elig && w_blit_elig) begin
      w_gid = ((REGS_PRIO != 0) || !r_rr_ptr) ? GID_REGS : GID_BLIT;
    end else if (w_regs_elig) begin
      w_gid = GID_REGS;
    end else if (w_blit_elig) begin
      w_gid = GID_BLIT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_gid1      <= GID_NONE;
      r_gid2      <= GID_NONE;
      r_regs_pend <= 1'b0;
      r_blit_pend <= 1'b0;
      r_rr_ptr    <= 1'b0;
      r_sel       <= 1'b0;
      r_wr        <= 1'b0;
      r_mask      <= 4'hF;
      r_addr      <= 16'h0000;
      r_data      <= 16'h0000;
    end else begin
      r_gid1 <= w_gid;
      r_gid2 <= r_gid1;
      r_sel  <= (w_gid != GID_NONE);
      r_wr   <= 1'b0;
      // vgen carries no write data, so vram_data_o keeps its last value
      case (w_gid)
        GID_VGEN: begin
          r_mask <= 4'hF;
          r_addr <= vgen_addr_i;
        end
        GID_REGS: begin
          r_wr   <= regs_wr_i;
          r_mask <= regs_wr_mask_i;
          r_addr <= regs_addr_i;
          r_data <= regs_data_i;
        end
        GID_BLIT: begin
          r_wr   <= blit_wr_i;
          r_mask <= blit_wr_mask_i;
          r_addr <= blit_addr_i;
          r_data <= blit_data_i;
        end
        default: ;
      endcase

      if (w_gid == GID_REGS) begin
        r_regs_pend <= 1'b1;
      end else if (r_gid2 == GID_REGS) begin
        r_regs_pend <= 1'b0;
      end
      if (w_gid == GID_BLIT) begin
        r_blit_pend <= 1'b1;
      end else if (r_gid2 == GID_BLIT) begin
        r_blit_pend <= 1'b0;
      end

      if ((REGS_PRIO == 0) && ((w_gid == GID_REGS) || (w_gid == GID_BLIT))) begin
        r_rr_ptr <= ~r_rr_ptr;
      end
    end
  end

  assign vram_sel_o     = r_sel;
  assign vram_wr_o      = r_wr;
  assign vram_wr_mask_o = r_mask;
  assign vram_addr_o    = r_addr;
  assign vram_data_o    = r_data;
  assign vgen_ack_o     = (r_gid2 == GID_VGEN);
  assign regs_ack_o     = (r_gid2 == GID_REGS);
  assign blit_ack_o     = (r_gid2 == GID_BLIT);
  assign data_o         = vram_data_i;

endmodule

// File: tb/tb_vram_arb.sv
// tb/tb_vram_arb.sv - scoreboard bench for vram_arb; VRAM read data model is addr ^ 16'hACDB
module tb_vram_arb;

  localparam logic [15:0] K = 16'hACDB;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        vgen_sel_i = 1'b0;
  logic [15:0] vgen_addr_i = '0;
  logic        vgen_ack_o;
  logic        regs_sel_i = 1'b0;
  logic        regs_wr_i = 1'b0;
  logic [3:0]  regs_wr_mask_i = 4'hF;
  logic [15:0] regs_addr_i = '0;
  logic [15:0] regs_data_i = '0;
  logic        regs_ack_o;
  logic        blit_sel_i = 1'b0;
  logic        blit_wr_i = 1'b0;
  logic [3:0]  blit_wr_mask_i = 4'hF;
  logic [15:0] blit_addr_i = '0;
  logic [15:0] blit_data_i = '0;
  logic        blit_ack_o;
  logic        vram_sel_o;
  logic        vram_wr_o;
  logic [3:0]  vram_wr_mask_o;
  logic [15:0] vram_addr_o;
  logic [15:0] vram_data_o;
  logic [15:0] vram_data_i = '0;
  logic [15:0] data_o;

  vram_arb #(.REGS_PRIO(0)) dut (
    .clk(clk), .reset_i(reset_i),
    .vgen_sel_i(vgen_sel_i), .vgen_addr_i(vgen_addr_i), .vgen_ack_o(vgen_ack_o),
    .regs_sel_i(regs_sel_i), .regs_wr_i(regs_wr_i), .regs_wr_mask_i(regs_wr_mask_i),
    .regs_addr_i(regs_addr_i), .regs_data_i(regs_data_i), .regs_ack_o(regs_ack_o),
    .blit_sel_i(blit_sel_i), .blit_wr_i(blit_wr_i), .blit_wr_mask_i(blit_wr_mask_i),
    .blit_addr_i(blit_addr_i), .blit_data_i(blit_data_i), .blit_ack_o(blit_ack_o),
    .vram_sel_o(vram_sel_o), .vram_wr_o(vram_wr_o), .vram_wr_mask_o(vram_wr_mask_o),
    .vram_addr_o(vram_addr_o), .vram_data_o(vram_data_o), .vram_data_i(vram_data_i),
    .data_o(data_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (vram_sel_o && !vram_wr_o) vram_data_i <= vram_addr_o ^ K;

  typedef struct {
    int          cyc;
    int          who;
    logic        wr;
    logic [3:0]  mask;
    logic [15:0] addr;
    logic [15:0] data;
    bit          chk_data;
  } exp_t;

  exp_t vq[$];
  exp_t aq[$];
  int n_total = 0;
  int n_pass  = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
  endfunction

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_vram(int c, logic wr, logic [3:0] m, logic [15:0] a, logic [15:0] d, bit cd);
    exp_t e;
    e.cyc = c; e.who = 0; e.wr = wr; e.mask = m; e.addr = a; e.data = d; e.chk_data = cd;
    vq.push_back(e);
  endtask

  task automatic exp_ack(int c, int who, logic wr, logic [15:0] d);
    exp_t e;
    e.cyc = c; e.who = who; e.wr = wr; e.mask = 4'hF; e.addr = '0; e.data = d; e.chk_data = !wr;
    aq.push_back(e);
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_sel"},  32'(vram_sel_o), 32'd0);
    chk({tag, "_wr"},   32'(vram_wr_o), 32'd0);
    chk({tag, "_mask"}, 32'(vram_wr_mask_o), 32'hF);
    chk({tag, "_addr"}, 32'(vram_addr_o), 32'd0);
    chk({tag, "_data"}, 32'(vram_data_o), 32'd0);
    chk({tag, "_acks"}, 32'({vgen_ack_o, regs_ack_o, blit_ack_o}), 32'd0);
  endtask

  // Monitor: every VRAM access and every ack must match the head of its queue
  always @(negedge clk) begin
    exp_t e;
    int   who;
    if (vram_sel_o === 1'b1) begin
      if (vq.size() == 0) begin
        chk("unexpected_vram_sel", 32'd1, 32'd0);
      end else begin
        e = vq.pop_front();
        chk("vram_cycle", cyc, e.cyc);
        chk("vram_wr", 32'(vram_wr_o), 32'(e.wr));
        chk("vram_mask", 32'(vram_wr_mask_o), 32'(e.mask));
        chk("vram_addr", 32'(vram_addr_o), 32'(e.addr));
        if (e.chk_data) chk("vram_data", 32'(vram_data_o), 32'(e.data));
      end
    end
    who = vgen_ack_o ? 1 : regs_ack_o ? 2 : blit_ack_o ? 3 : 0;
    if (who != 0) begin
      chk("ack_onehot", 32'($countones({vgen_ack_o, regs_ack_o, blit_ack_o})), 32'd1);
      if (aq.size() == 0) begin
        chk("unexpected_ack", who, 32'd0);
      end else begin
        e = aq.pop_front();
        chk("ack_cycle", cyc, e.cyc);
        chk("ack_who", who, e.who);
        if (e.chk_data) chk("ack_data", 32'(data_o), 32'(e.data));
      end
    end
  end

  initial begin
    int n;
    int m;
    tick(3);
    chk_reset_outputs("reset");
    reset_i = 1'b0;
    tick(2);

    // blit read
    n = cyc;
    blit_sel_i = 1'b1; blit_wr_i = 1'b0; blit_wr_mask_i = 4'hF; blit_addr_i = 16'h1234; blit_data_i = 16'h0000;
    exp_vram(n + 1, 1'b0, 4'hF, 16'h1234, 16'h0000, 1'b1);
    exp_ack(n + 2, 3, 1'b0, 16'hBEEF);
    tick(3);
    blit_sel_i = 1'b0;
    tick(2);
    chk("idle_sel", 32'(vram_sel_o), 32'd0);
    chk("idle_addr_hold", 32'(vram_addr_o), 32'h1234);

    // blit write with partial mask at top address
    n = cyc;
    blit_sel_i = 1'b1; blit_wr_i = 1'b1; blit_wr_mask_i = 4'b0101; blit_addr_i = 16'hFFFF; blit_data_i = 16'hA5A5;
    exp_vram(n + 1, 1'b1, 4'b0101, 16'hFFFF, 16'hA5A5, 1'b1);
    exp_ack(n + 2, 3, 1'b1, 16'h0000);
    tick(3);
    blit_sel_i = 1'b0; blit_wr_i = 1'b0; blit_wr_mask_i = 4'hF;
    tick(2);

    // 3-way collision
    n = cyc;
    vgen_sel_i = 1'b1; vgen_addr_i = 16'h0100;
    regs_sel_i = 1'b1; regs_wr_i = 1'b0; regs_addr_i = 16'h2000;
    blit_sel_i = 1'b1; blit_addr_i = 16'h3000; blit_data_i = 16'h0000;
    exp_vram(n + 1, 1'b0, 4'hF, 16'h0100, 16'h0000, 1'b0);
    exp_vram(n + 2, 1'b0, 4'hF, 16'h2000, 16'h0000, 1'b1);
    exp_vram(n + 3, 1'b0, 4'hF, 16'h3000, 16'h0000, 1'b1);
    exp_ack(n + 2, 1, 1'b0, 16'hADDB);
    exp_ack(n + 3, 2, 1'b0, 16'h8CDB);
    exp_ack(n + 4, 3, 1'b0, 16'h9CDB);
    tick(1);
    vgen_sel_i = 1'b0;
    tick(3);
    regs_sel_i = 1'b0;
    tick(1);
    blit_sel_i = 1'b0;
    tick(2);

    // round-robin with both requesters holding sel
    n = cyc;
    regs_sel_i = 1'b1; regs_addr_i = 16'h0010;
    blit_sel_i = 1'b1; blit_addr_i = 16'h0020;
    for (int k = 0; k < 3; k++) begin
      exp_vram(n + 3 * k + 1, 1'b0, 4'hF, 16'h0010, 16'h0000, 1'b1);
      exp_vram(n + 3 * k + 2, 1'b0, 4'hF, 16'h0020, 16'h0000, 1'b1);
      exp_ack(n + 3 * k + 2, 2, 1'b0, 16'hACCB);
      exp_ack(n + 3 * k + 3, 3, 1'b0, 16'hACFB);
    end
    tick(9);
    regs_sel_i = 1'b0; blit_sel_i = 1'b0;
    tick(2);

    // regs alone moves rr to favour blit, then a tie goes to blit
    n = cyc;
    regs_sel_i = 1'b1; regs_addr_i = 16'h0040;
    exp_vram(n + 1, 1'b0, 4'hF, 16'h0040, 16'h0000, 1'b1);
    exp_ack(n + 2, 2, 1'b0, 16'hAC9B);
    tick(3);
    regs_sel_i = 1'b0;
    tick(2);
    m = cyc;
    regs_sel_i = 1'b1; regs_addr_i = 16'h0050;
    blit_sel_i = 1'b1; blit_addr_i = 16'h0060;
    exp_vram(m + 1, 1'b0, 4'hF, 16'h0060, 16'h0000, 1'b1);
    exp_vram(m + 2, 1'b0, 4'hF, 16'h0050, 16'h0000, 1'b1);
    exp_ack(m + 2, 3, 1'b0, 16'hACBB);
    exp_ack(m + 3, 2, 1'b0, 16'hAC8B);
    tick(3);
    blit_sel_i = 1'b0;
    tick(1);
    regs_sel_i = 1'b0;
    tick(2);

    // vgen streaming 8 cycles while blit waits
    n = cyc;
    blit_sel_i = 1'b1; blit_addr_i = 16'h0777;
    for (int i = 0; i < 8; i++) begin
      vgen_sel_i = 1'b1; vgen_addr_i = 16'(16'h8000 + i);
      exp_vram(n + i + 1, 1'b0, 4'hF, 16'(16'h8000 + i), 16'h0000, 1'b0);
      exp_ack(n + i + 2, 1, 1'b0, 16'((16'h8000 + i) ^ K));
      tick(1);
    end
    vgen_sel_i = 1'b0;
    exp_vram(n + 9, 1'b0, 4'hF, 16'h0777, 16'h0000, 1'b1);
    exp_ack(n + 10, 3, 1'b0, 16'hABAC);
    tick(3);
    blit_sel_i = 1'b0;
    tick(2);

    // reset while a regs access is in flight
    n = cyc;
    regs_sel_i = 1'b1; regs_addr_i = 16'h0ABC;
    exp_vram(n + 1, 1'b0, 4'hF, 16'h0ABC, 16'h0000, 1'b1);
    tick(1);
    reset_i = 1'b1; regs_sel_i = 1'b0;
    tick(1);
    chk_reset_outputs("midreset");
    tick(1);
    reset_i = 1'b0;
    tick(3);
    chk_reset_outputs("postreset");

    // reset returns rr to favour regs
    m = cyc;
    regs_sel_i = 1'b1; regs_addr_i = 16'h0011;
    blit_sel_i = 1'b1; blit_addr_i = 16'h0022;
    exp_vram(m + 1, 1'b0, 4'hF, 16'h0011, 16'h0000, 1'b1);
    exp_vram(m + 2, 1'b0, 4'hF, 16'h0022, 16'h0000, 1'b1);
    exp_ack(m + 2, 2, 1'b0, 16'hACCA);
    exp_ack(m + 3, 3, 1'b0, 16'hACF9);
    tick(3);
    regs_sel_i = 1'b0;
    tick(1);
    blit_sel_i = 1'b0;
    tick(3);

    chk("vram_queue_drained", 32'(vq.size()), 32'd0);
    chk("ack_queue_drained", 32'(aq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
